// File: rtl/qpsk_pkg.sv
// Shared constants and the I/Q sample type for the QPSK transmit chain.
package qpsk_pkg;

   localparam int QPSK_SPS_DEFAULT = 16;
   localparam logic signed [15:0] QPSK_AMP_DEFAULT = 16'sd23170;
   localparam int DIBIT_W = 2;
   localparam int DIBITS_PER_WORD = 16;
   localparam int IQ_W = 16;

   typedef struct packed {
      logic signed [IQ_W-1:0] i;
      logic signed [IQ_W-1:0] q;
   } iq_sample_t;

   // Amplitude is always below full scale, so plain two's complement negation cannot overflow.
   function automatic logic signed [IQ_W-1:0] iq_negate(input logic signed [IQ_W-1:0] x);
      return -x;
   endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Combinational Gray mapper: dibit[1] selects the sign of I, dibit[0] selects the sign of Q.
module qpsk_symbol_mapper
   import qpsk_pkg::*;
#(
   parameter logic signed [IQ_W-1:0] AMPLITUDE = QPSK_AMP_DEFAULT
) (
   input  logic [DIBIT_W-1:0] dibit_i,
   output iq_sample_t         iq_o
);

   localparam logic signed [IQ_W-1:0] NEG_AMP = iq_negate(AMPLITUDE);

   always_comb begin
      iq_o.i = dibit_i[1] ? NEG_AMP : AMPLITUDE;
      iq_o.q = dibit_i[0] ? NEG_AMP : AMPLITUDE;
   end

endmodule

// File: rtl/qpsk_mod.sv
// QPSK modulator: 16 packed dibits per AXI-Stream word, each held for SPS samples.
// Define QPSK_MOD_ZERO_STUFF_EN to emit the point only on the first sample of each symbol.
module qpsk_mod
   import qpsk_pkg::*;
#(
   parameter int                      SPS       = QPSK_SPS_DEFAULT,
   parameter logic signed [IQ_W-1:0]  AMPLITUDE = QPSK_AMP_DEFAULT
) (
   input  logic        ce_clk,
   input  logic        ce_rst,
   input  logic        clear,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [31:0] sym_count
);

   localparam int SAMP_W  = $clog2(SPS);
   localparam int DIBIX_W = $clog2(DIBITS_PER_WORD);
   localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(SPS - 1);
   localparam logic [DIBIX_W-1:0] DIBIT_LAST = DIBIX_W'(DIBITS_PER_WORD - 1);

   logic                full_q, full_d;
   logic                last_q, last_d;
   logic [31:0]         word_q, word_d;
   logic [DIBIX_W-1:0]  dibit_q, dibit_d;
   logic [SAMP_W-1:0]   samp_q, samp_d;
   logic [31:0]         sym_q, sym_d;

   logic                samp_end, dibit_end, in_hs, out_hs;
   logic [DIBIT_W-1:0]  cur_dibit;
   iq_sample_t          point;

   assign samp_end  = (samp_q == SAMP_LAST);
   assign dibit_end = (dibit_q == DIBIT_LAST);
   assign i_tready  = ce_rst & (~full_q | (o_tready & samp_end & dibit_end));
   assign in_hs     = i_tvalid & i_tready;
   assign out_hs    = full_q & o_tready;

   // Inverting the index turns dibit 0 into the MSB pair of the word.
   assign cur_dibit = word_q[{~dibit_q, 1'b0} +: DIBIT_W];

   qpsk_symbol_mapper #(.AMPLITUDE(AMPLITUDE)) u_mapper (
      .dibit_i (cur_dibit),
      .iq_o    (point)
   );

   always_comb begin
      full_d  = full_q;
      last_d  = last_q;
      word_d  = word_q;
      dibit_d = dibit_q;
      samp_d  = samp_q;
      sym_d   = sym_q;
      if (out_hs) begin
         if (!samp_end) begin
            samp_d = samp_q + SAMP_W'(1);
         end else begin
            samp_d = '0;
            sym_d  = sym_q + 32'd1;
            if (!dibit_end) begin
               dibit_d = dibit_q + DIBIX_W'(1);
            end else begin
               dibit_d = '0;
               full_d  = i_tvalid;
            end
         end
      end
      if (in_hs) begin
         full_d  = 1'b1;
         last_d  = i_tlast;
         word_d  = i_tdata;
         dibit_d = '0;
         samp_d  = '0;
      end
      // Flush wins over any handshake in the same cycle.
      if (clear) begin
         full_d  = 1'b0;
         dibit_d = '0;
         samp_d  = '0;
         sym_d   = '0;
      end
   end

   always_ff @(posedge ce_clk or negedge ce_rst) begin
      if (!ce_rst) begin
         full_q  <= 1'b0;
         last_q  <= 1'b0;
         dibit_q <= '0;
         samp_q  <= '0;
         sym_q   <= '0;
      end else begin
         full_q  <= full_d;
         last_q  <= last_d;
         dibit_q <= dibit_d;
         samp_q  <= samp_d;
         sym_q   <= sym_d;
      end
   end

   always_ff @(posedge ce_clk) begin
      word_q <= word_d;
   end

   always_comb begin
      o_tdata = '0;
`ifdef QPSK_MOD_ZERO_STUFF_EN
      if (full_q && (samp_q == '0)) o_tdata = point;
`else
      if (full_q) o_tdata = point;
`endif
   end

   assign o_tvalid  = full_q;
   assign o_tlast   = full_q & last_q & dibit_end & samp_end;
   assign sym_count = sym_q;

endmodule

// File: tb/tb_qpsk_mod.sv
// Directed bench for qpsk_mod at SPS=16; adapts its expectations when QPSK_MOD_ZERO_STUFF_EN is defined.
module tb_qpsk_mod;

   logic        ce_clk = 1'b0;
   logic        ce_rst;
   logic        clear;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;
   logic [31:0] sym_count;

   int n_assert = 0;
   int n_fail   = 0;
   bit zs;

   localparam logic [31:0] P00 = 32'h5A825A82;
   localparam logic [31:0] P01 = 32'h5A82A57E;
   localparam logic [31:0] P10 = 32'hA57E5A82;
   localparam logic [31:0] P11 = 32'hA57EA57E;

   always #5 ce_clk = ~ce_clk;

   qpsk_mod #(.SPS(16), .AMPLITUDE(16'sd23170)) dut (
      .ce_clk    (ce_clk),
      .ce_rst    (ce_rst),
      .clear     (clear),
      .i_tdata   (i_tdata),
      .i_tlast   (i_tlast),
      .i_tvalid  (i_tvalid),
      .i_tready  (i_tready),
      .o_tdata   (o_tdata),
      .o_tlast   (o_tlast),
      .o_tvalid  (o_tvalid),
      .o_tready  (o_tready),
      .sym_count (sym_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_samp(input logic [31:0] w, input int s);
      logic [31:0] sh;
      int k;
      k  = s / 16;
      sh = w >> (30 - 2 * k);
      if (zs && (s % 16) != 0) return 32'h0;
      case (sh[1:0])
         2'b00:   return P00;
         2'b01:   return P01;
         2'b10:   return P10;
         default: return P11;
      endcase
   endfunction

   task automatic load(input logic [31:0] w, input bit lastw, input bit keep);
      @(negedge ce_clk);
      i_tdata  = w;
      i_tlast  = lastw;
      i_tvalid = 1'b1;
      chk("load_irdy", {31'b0, i_tready}, 32'd1);
      @(posedge ce_clk);
      #1;
      if (!keep) i_tvalid = 1'b0;
   endtask

   // Consumes n samples of word w; every cycle (stalled or not) must show the current expected sample.
   task automatic expect_word(input logic [31:0] w, input bit lastw, input int n,
                              input bit rnd, input bit nxt, output int cyc);
      int s;
      s   = 0;
      cyc = 0;
      while (s < n && cyc < 4000) begin
         @(negedge ce_clk);
         o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cyc++;
         chk("out_vld", {31'b0, o_tvalid}, 32'd1);
         chk("out_data", o_tdata, exp_samp(w, s));
         chk("out_last", {31'b0, o_tlast}, {31'b0, (lastw && s == 255)});
         if (nxt && s == 255 && o_tready) chk("b2b_irdy", {31'b0, i_tready}, 32'd1);
         @(posedge ce_clk);
         if (o_tready) begin
            if (nxt && s == 255) begin
               #1 i_tvalid = 1'b0;
            end
            s++;
         end
      end
      if (s < n) chk("timeout", s, n);
   endtask

   initial begin
      int c1, c2;
`ifdef QPSK_MOD_ZERO_STUFF_EN
      zs = 1'b1;
`else
      zs = 1'b0;
`endif
      ce_rst   = 1'b0;
      clear    = 1'b0;
      i_tdata  = '0;
      i_tlast  = 1'b0;
      i_tvalid = 1'b1;
      o_tready = 1'b0;

      // reset state
      repeat (3) @(negedge ce_clk);
      chk("rst_vld", {31'b0, o_tvalid}, 32'd0);
      chk("rst_data", o_tdata, 32'd0);
      chk("rst_last", {31'b0, o_tlast}, 32'd0);
      chk("rst_sym", sym_count, 32'd0);
      chk("rst_irdy", {31'b0, i_tready}, 32'd0);
      i_tvalid = 1'b0;
      ce_rst   = 1'b1;
      @(negedge ce_clk);
      chk("post_rst_irdy", {31'b0, i_tready}, 32'd1);
      chk("post_rst_vld", {31'b0, o_tvalid}, 32'd0);

      // single word, ready held high
      load(32'h1B1B1B1B, 1'b1, 1'b0);
      expect_word(32'h1B1B1B1B, 1'b1, 256, 1'b0, 1'b0, c1);
      chk("single_cycles", c1, 32'd256);
      @(negedge ce_clk);
      chk("single_idle", {31'b0, o_tvalid}, 32'd0);
      chk("single_sym", sym_count, 32'd16);

      // two words back to back, no bubble
      load(32'h1B1B1B1B, 1'b0, 1'b1);
      i_tdata = 32'hE4E4E4E4;
      i_tlast = 1'b1;
      expect_word(32'h1B1B1B1B, 1'b0, 256, 1'b0, 1'b1, c1);
      expect_word(32'hE4E4E4E4, 1'b1, 256, 1'b0, 1'b0, c2);
      chk("b2b_cycles", c1 + c2, 32'd512);
      @(negedge ce_clk);
      chk("b2b_idle", {31'b0, o_tvalid}, 32'd0);
      chk("b2b_sym", sym_count, 32'd48);

      // random backpressure
      load(32'h1B1B1B1B, 1'b1, 1'b0);
      expect_word(32'h1B1B1B1B, 1'b1, 256, 1'b1, 1'b0, c1);
      @(negedge ce_clk);
      o_tready = 1'b1;
      chk("rnd_sym", sym_count, 32'd64);

      // clear mid-word after 40 samples
      load(32'h1B1B1B1B, 1'b0, 1'b0);
      expect_word(32'h1B1B1B1B, 1'b0, 40, 1'b0, 1'b0, c1);
      @(negedge ce_clk);
      chk("pre_clear_sym", sym_count, 32'd66);
      clear = 1'b1;
      @(posedge ce_clk);
      #1 clear = 1'b0;
      @(negedge ce_clk);
      chk("clear_vld", {31'b0, o_tvalid}, 32'd0);
      chk("clear_sym", sym_count, 32'd0);
      chk("clear_irdy", {31'b0, i_tready}, 32'd1);
      load(32'hE4E4E4E4, 1'b1, 1'b0);
      expect_word(32'hE4E4E4E4, 1'b1, 256, 1'b0, 1'b0, c1);
      @(negedge ce_clk);
      chk("after_clear_sym", sym_count, 32'd16);

      // asynchronous reset mid-word
      load(32'h1B1B1B1B, 1'b1, 1'b0);
      expect_word(32'h1B1B1B1B, 1'b1, 10, 1'b0, 1'b0, c1);
      @(negedge ce_clk);
      #2 ce_rst = 1'b0;
      #1;
      chk("arst_vld", {31'b0, o_tvalid}, 32'd0);
      chk("arst_data", o_tdata, 32'd0);
      chk("arst_sym", sym_count, 32'd0);
      chk("arst_irdy", {31'b0, i_tready}, 32'd0);
      @(negedge ce_clk);
      ce_rst = 1'b1;

      // all-zero word: constant point, or zero-stuffed when that build is selected
      load(32'h00000000, 1'b1, 1'b0);
      expect_word(32'h00000000, 1'b1, 256, 1'b0, 1'b0, c1);
      @(negedge ce_clk);
      chk("zero_word_sym", sym_count, 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/qpsk_mod.md
# qpsk_mod

Baseband QPSK modulator for the RFNoC QPSK chain; the transmit counterpart of the Costas/bit-sync receiver. Accepts packed dibits on a 32-bit AXI-Stream, Gray-maps each dibit to a constant-amplitude {I,Q} point and upsamples to SPS samples per symbol. The output is 32-bit {I[31:16], Q[15:0]} samples with packet framing preserved. It sits between the axi_wrapper master data port and the slave data port of a noc_block, matching the receiver's 16-samples-per-symbol convention.

## Interface
Parameters:
- SPS, 16, samples per symbol; legal range 2..256.
- AMPLITUDE, 16'sd23170, magnitude of each I/Q component (0.707 full scale).

Ports:
- ce_clk  in  1  sole clock.
- ce_rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active-high.
- i_tdata  in  32  16 dibits, MSB pair first; symbol k = i_tdata[31-2k -: 2].
- i_tlast  in  1  last word of the packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  32  {I, Q}, two's complement.
- o_tlast  out  1  last sample of the packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- sym_count  out  32  symbols completed since reset/clear; wraps.

## Operation
- State: word register, last flag, full flag, dibit_idx (0..15), samp_idx (0..SPS-1), sym_count.
- Two effective states:
  - EMPTY (full=0).
  - ACTIVE (full=1).
- i_tready:
  - 1 when EMPTY.
  - In ACTIVE, 1 only when all of: o_tready=1, samp_idx=SPS-1, dibit_idx=15.
  - Forced 0 while ce_rst is low.
- Input handshake (i_tvalid & i_tready): load word and last flag, set full, zero both indices.
- o_tvalid = full.
- o_tdata = map(current dibit) when full, 0 otherwise.
- o_tlast = last & (dibit_idx==15) & (samp_idx==SPS-1).
- Mapping (Gray), with A = AMPLITUDE:
  - 00 -> (+A, +A)
  - 01 -> (+A, -A)
  - 10 -> (-A, +A)
  - 11 -> (-A, -A)
  - Negation is exact two's complement; no saturation needed.
- Output handshake (o_tvalid & o_tready):
  - samp_idx < SPS-1: increment samp_idx.
  - Otherwise: samp_idx to 0, sym_count+1 (wraps 0xFFFFFFFF -> 0).
    - dibit_idx < 15: increment dibit_idx.
    - dibit_idx = 15: dibit_idx to 0, and full <= i_tvalid (simultaneous reload when valid).
- clear: full, indices and sym_count go to 0 on the next edge. Overrides any simultaneous handshake; the word accepted that cycle is discarded.

## Timing
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0 (1 after deassertion), sym_count=0.
- Latency: word accepted at edge k; its first sample is valid in the cycle following edge k.
- Back-to-back words with o_tready held high produce no bubble; throughput is 1 sample per clock.
- While o_tvalid=1 and o_tready=0: o_tdata and o_tlast are held stable and no index advances.
- Reset asserted mid-word: state is dropped immediately and asynchronously.
- One input word yields exactly 16*SPS output samples.

## Configuration
- QPSK_MOD_ZERO_STUFF_EN defined: o_tdata carries the mapped point only at samp_idx=0 and 32'h0 at samp_idx 1..SPS-1. Use this when a downstream pulse-shaping FIR follows.
- Undefined: the mapped point is held for all SPS samples (rectangular pulse).
- Handshake, o_tlast and sym_count are identical in both builds.

## Structure
- Package qpsk_pkg holds:
  - QPSK_SPS_DEFAULT = 16.
  - QPSK_AMP_DEFAULT = 23170.
  - Dibit width and dibits-per-word (16) constants.
  - The iq_sample_t typedef (two signed 16-bit fields).
- Sub-module qpsk_symbol_mapper: combinational 2-bit dibit -> iq_sample_t, parameterised by AMPLITUDE. The receiver-side test bench reuses it as a reference model.

## Test plan
1. Reset with ce_rst low, then release:
   - During reset: o_tvalid=0, o_tdata=0, sym_count=0, i_tready=0.
   - One cycle after release: i_tready=1.
2. Word 0x1B1B1B1B with i_tlast=1, o_tready=1, SPS=16:
   - Output is 256 samples in four 16-sample runs, repeating: 0x5A825A82, 0x5A82A57E, 0xA57E5A82, 0xA57EA57E.
   - o_tlast asserts only on sample 256; sym_count=16.
3. Two words back-to-back, o_tready=1:
   - 512 consecutive valid cycles.
   - i_tready is high in the cycle of the 256th sample handshake.
   - o_tlast only at sample 512 when only the second word has tlast.
4. Random o_tready (50%):
   - o_tdata/o_tlast never change while stalled.
   - Sample sequence is identical to scenario 2.
5. clear pulsed after 40 output samples:
   - o_tvalid=0 next cycle; sym_count=0.
   - Next word restarts at dibit 0, sample 0.
6. With QPSK_MOD_ZERO_STUFF_EN, word 0x00000000:
   - Each 16-sample run is 0x5A825A82 followed by 15 × 0x00000000.
